// File: rtl/mm_param.sv
// Sequential matrix multiplier: reads dimensions, then A and B (optionally C)
// element by element from a shared memory and writes C = A*B (+ C_old) row-major.
module mm_param #(
  parameter  int DW     = 20,
  parameter  int AW     = 20,
  parameter  int MAXDIM = 1024,
  localparam int OW     = 2*DW + AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          acc_mode,
  input  logic          signed_mode,
  input  logic [DW-1:0] read_data,
  output logic [AW-1:0] i,
  output logic [AW-1:0] j,
  output logic [1:0]    index,
  output logic          read,
  output logic          write,
  output logic [OW-1:0] write_data,
  output logic          busy,
  output logic          finish,
  output logic          error
);

  typedef enum logic [2:0] {
    IDLE, DIM, CHK, RDA, RDB, RDC, WR, DONE
  } state_t;

  localparam logic [DW:0] MAXD = (DW+1)'(MAXDIM);

  state_t        state, state_nx;
  logic [1:0]    dcnt;
  logic [DW-1:0] dim_m, dim_k, dim_n;
  logic [AW-1:0] row, col, kk;
  logic [DW-1:0] a_reg;
  logic [OW-1:0] sum;
  logic          acc_r, sgn_r, err_r;
  logic          last_k, last_col, last_row, dim_bad;

  // Widen an element to accumulator width; the sign bit only replicates in signed mode.
  function automatic logic [OW-1:0] ext(input logic [DW-1:0] v, input logic sgn);
    return {{(OW-DW){sgn & v[DW-1]}}, v};
  endfunction

  // Low OW bits of the product are exact in both modes; higher bits wrap away.
  function automatic logic [OW-1:0] mul_ext(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                            input logic sgn);
    return ext(x, sgn) * ext(y, sgn);
  endfunction

  assign last_k   = (DW'(kk)  == dim_k - DW'(1));
  assign last_col = (DW'(col) == dim_n - DW'(1));
  assign last_row = (DW'(row) == dim_m - DW'(1));
  assign dim_bad  = (dim_m == '0) || (dim_k == '0) || (dim_n == '0) ||
                    ({1'b0, dim_m} > MAXD) || ({1'b0, dim_k} > MAXD) ||
                    ({1'b0, dim_n} > MAXD);

  assign busy   = (state != IDLE);
  assign finish = (state == DONE);
  assign error  = err_r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    read       = 1'b0;
    write      = 1'b0;
    index      = 2'd0;
    i          = '0;
    j          = '0;
    write_data = '0;
    case (state)
      IDLE: if (start) state_nx = DIM;
      DIM: begin
        read  = 1'b1;
        index = 2'd3;
        i     = AW'(dcnt);
        if (dcnt == 2'd2) state_nx = CHK;
      end
      CHK: state_nx = dim_bad ? DONE : RDA;
      RDA: begin
        read     = 1'b1;
        index    = 2'd0;
        i        = row;
        j        = kk;
        state_nx = RDB;
      end
      RDB: begin
        read  = 1'b1;
        index = 2'd1;
        i     = kk;
        j     = col;
        if (!last_k)    state_nx = RDA;
        else if (acc_r) state_nx = RDC;
        else            state_nx = WR;
      end
      RDC: begin
        read     = 1'b1;
        index    = 2'd2;
        i        = row;
        j        = col;
        state_nx = WR;
      end
      WR: begin
        write      = 1'b1;
        index      = 2'd2;
        i          = row;
        j          = col;
        write_data = sum;
        state_nx   = (last_row && last_col) ? DONE : RDA;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dcnt  <= '0;
      dim_m <= '0;
      dim_k <= '0;
      dim_n <= '0;
      row   <= '0;
      col   <= '0;
      kk    <= '0;
      a_reg <= '0;
      sum   <= '0;
      acc_r <= 1'b0;
      sgn_r <= 1'b0;
      err_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          acc_r <= acc_mode;
          sgn_r <= signed_mode;
          err_r <= 1'b0;
          dcnt  <= '0;
        end
        DIM: begin
          dcnt <= dcnt + 2'd1;
          case (dcnt)
            2'd0:    dim_m <= read_data;
            2'd1:    dim_k <= read_data;
            default: dim_n <= read_data;
          endcase
        end
        CHK: begin
          if (dim_bad) begin
            err_r <= 1'b1;
          end else begin
            row <= '0;
            col <= '0;
            kk  <= '0;
            sum <= '0;
          end
        end
        RDA: a_reg <= read_data;
        RDB: begin
          sum <= sum + mul_ext(a_reg, read_data, sgn_r);
          if (!last_k) kk <= kk + AW'(1);
        end
        RDC: sum <= sum + ext(read_data, sgn_r);
        WR: begin
          sum <= '0;
          kk  <= '0;
          if (last_col) begin
            col <= '0;
            row <= row + AW'(1);
          end else begin
            col <= col + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_param.sv
// Randomized bench for mm_param: a behavioural memory plus a plain-arithmetic
// matrix model predict every write, the latency and the error flag.
module tb_mm_param;
  localparam int DW = 20;
  localparam int AW = 20;
  localparam int MAXDIM = 1024;
  localparam int OW = 2*DW + AW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          acc_mode = 1'b0;
  logic          signed_mode = 1'b0;
  logic [DW-1:0] read_data;
  logic [AW-1:0] i, j;
  logic [1:0]    index;
  logic          read, write;
  logic [OW-1:0] write_data;
  logic          busy, finish, error;

  mm_param #(.DW(DW), .AW(AW), .MAXDIM(MAXDIM)) dut (
    .clk(clk), .reset(reset), .start(start), .acc_mode(acc_mode),
    .signed_mode(signed_mode), .read_data(read_data), .i(i), .j(j),
    .index(index), .read(read), .write(write), .write_data(write_data),
    .busy(busy), .finish(finish), .error(error)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem_a [8][8];
  logic [DW-1:0] mem_b [8][8];
  logic [DW-1:0] mem_c [8][8];
  logic [DW-1:0] mem_d [4];

  always_comb begin
    read_data = '0;
    if (i < 8 && j < 8) begin
      case (index)
        2'd0: read_data = mem_a[i[2:0]][j[2:0]];
        2'd1: read_data = mem_b[i[2:0]][j[2:0]];
        2'd2: read_data = mem_c[i[2:0]][j[2:0]];
        default: read_data = (i < 4) ? mem_d[i[1:0]] : '0;
      endcase
    end
  end

  typedef struct {int r; int c; logic [OW-1:0] d;} wr_t;
  wr_t got_q[$];
  wr_t exp_q[$];
  int  n_both, n_rd_data, n_rd_c, n_fin, n_wr_idx_bad;
  int  total = 0;
  int  bad = 0;

  always @(negedge clk) begin
    if (write) got_q.push_back('{int'(i), int'(j), write_data});
    if (write && index != 2'd2) n_wr_idx_bad++;
    if (read && write) n_both++;
    if (read && index != 2'd3) n_rd_data++;
    if (read && index == 2'd2) n_rd_c++;
    if (finish) n_fin++;
  end

  function automatic longint ext(input logic [DW-1:0] v, input bit sgn);
    return sgn ? longint'($signed(v)) : longint'(v);
  endfunction

  task automatic fill_random(input int m, input int k, input int n);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        mem_a[r][c] = DW'($urandom);
        mem_b[r][c] = DW'($urandom);
        mem_c[r][c] = DW'($urandom);
      end
    mem_d[0] = DW'(m); mem_d[1] = DW'(k); mem_d[2] = DW'(n); mem_d[3] = '0;
  endtask

  task automatic clear_mon();
    got_q.delete();
    n_both = 0; n_rd_data = 0; n_rd_c = 0; n_fin = 0; n_wr_idx_bad = 0;
  endtask

  // Runs one multiply over the current memory contents and checks everything observable.
  task automatic run_mm(input bit am, input bit sm, input string tag);
    int  m, k, n, lat, cnt;
    bit  got, err_exp;
    longint acc;
    m = int'(mem_d[0]); k = int'(mem_d[1]); n = int'(mem_d[2]);
    err_exp = (m == 0 || k == 0 || n == 0 || m > MAXDIM || k > MAXDIM || n > MAXDIM);
    exp_q.delete();
    if (!err_exp)
      for (int r = 0; r < m; r++)
        for (int c = 0; c < n; c++) begin
          acc = am ? ext(mem_c[r][c], sm) : 0;
          for (int x = 0; x < k; x++) acc += ext(mem_a[r][x], sm) * ext(mem_b[x][c], sm);
          exp_q.push_back('{r, c, OW'(acc)});
        end
    lat = err_exp ? 5 : 5 + m*n*(2*k + 1 + int'(am));
    @(negedge clk);
    clear_mon();
    acc_mode = am; signed_mode = sm; start = 1'b1;
    cnt = 0; got = 0;
    while (!got && cnt < 4000) begin
      @(negedge clk);
      start = 1'b0;
      cnt++;
      if (cnt == 1) begin
        total++;
        if ({busy, error} !== 2'b10) begin
          bad++; $display("FAIL %s busy/error after start got=%b exp=10", tag, {busy, error});
        end
      end
      if (finish) got = 1;
    end
    total++;
    if (!got || cnt != lat) begin
      bad++; $display("FAIL %s latency got=%0d exp=%0d", tag, got ? cnt : -1, lat);
    end
    total++;
    if (error !== err_exp) begin
      bad++; $display("FAIL %s error got=%b exp=%b", tag, error, err_exp);
    end
    @(negedge clk);
    total++;
    if ({busy, finish, error} !== {1'b0, 1'b0, err_exp}) begin
      bad++; $display("FAIL %s after done busy/finish/error got=%b", tag, {busy, finish, error});
    end
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL %s write count got=%0d exp=%0d", tag, got_q.size(), exp_q.size());
    end
    for (int w = 0; w < exp_q.size() && w < got_q.size(); w++) begin
      total++;
      if (got_q[w].r != exp_q[w].r || got_q[w].c != exp_q[w].c || got_q[w].d !== exp_q[w].d) begin
        bad++;
        $display("FAIL %s write%0d got=(%0d,%0d)=%0h exp=(%0d,%0d)=%0h", tag, w,
                 got_q[w].r, got_q[w].c, got_q[w].d, exp_q[w].r, exp_q[w].c, exp_q[w].d);
      end
    end
    total++;
    if (n_both != 0 || n_wr_idx_bad != 0) begin
      bad++; $display("FAIL %s strobe conflict got=%0d/%0d exp=0/0", tag, n_both, n_wr_idx_bad);
    end
    total++;
    if (n_rd_data != (err_exp ? 0 : m*n*(2*k + int'(am))) || n_rd_c != (am && !err_exp ? m*n : 0)) begin
      bad++; $display("FAIL %s data reads got=%0d c=%0d", tag, n_rd_data, n_rd_c);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b1; acc_mode = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, read, write, finish, error, index, i, j, write_data} !== '0) begin
      bad++; $display("FAIL reset outputs got=%b/%b/%b/%b/%b exp=0", busy, read, write, finish, error);
    end
    start = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, read, finish} !== 3'b000) begin
      bad++; $display("FAIL reset release idle got=%b exp=000", {busy, read, finish});
    end
  endtask

  task automatic test_known_2x2();
    fill_random(2, 2, 2);
    mem_a[0][0] = 1; mem_a[0][1] = 2; mem_a[1][0] = 3; mem_a[1][1] = 4;
    mem_b[0][0] = 5; mem_b[0][1] = 6; mem_b[1][0] = 7; mem_b[1][1] = 8;
    run_mm(1'b0, 1'b0, "known2x2");
    total++;
    if (got_q.size() != 4 || got_q[0].d !== OW'(19) || got_q[1].d !== OW'(22) ||
        got_q[2].d !== OW'(43) || got_q[3].d !== OW'(50)) begin
      bad++; $display("FAIL known2x2 literal values got_n=%0d exp=19,22,43,50", got_q.size());
    end
  endtask

  task automatic test_neg_one();
    fill_random(1, 1, 1);
    mem_a[0][0] = '1; mem_b[0][0] = '1;
    run_mm(1'b0, 1'b1, "neg1_signed");
    total++;
    if (got_q.size() != 1 || got_q[0].d !== OW'(1)) begin
      bad++; $display("FAIL neg1_signed value got_n=%0d exp=1", got_q.size());
    end
    run_mm(1'b0, 1'b0, "neg1_unsigned");
    total++;
    if (got_q.size() != 1 || got_q[0].d !== OW'(((64'd1 << DW) - 1) * ((64'd1 << DW) - 1))) begin
      bad++; $display("FAIL neg1_unsigned value got_n=%0d", got_q.size());
    end
  endtask

  task automatic test_acc();
    fill_random(1, 2, 1);
    mem_a[0][0] = 2; mem_a[0][1] = 3; mem_b[0][0] = 4; mem_b[1][0] = 5; mem_c[0][0] = 7;
    run_mm(1'b1, 1'b0, "acc");
    total++;
    if (got_q.size() != 1 || got_q[0].d !== OW'(30)) begin
      bad++; $display("FAIL acc value got_n=%0d exp=30", got_q.size());
    end
  endtask

  task automatic test_dim_errors();
    fill_random(0, 3, 3);
    run_mm(1'b0, 1'b0, "dim_zero");
    fill_random(2, MAXDIM + 1, 2);
    run_mm(1'b1, 1'b1, "dim_big");
    fill_random(2, 3, 1);
    run_mm(1'b0, 1'b1, "err_cleared");
  endtask

  task automatic test_random();
    for (int t = 0; t < 10; t++) begin
      fill_random($urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 4));
      run_mm(1'($urandom), 1'($urandom), $sformatf("rand%0d", t));
    end
  endtask

  task automatic test_reset_midrun();
    int cnt;
    fill_random(2, 2, 2);
    @(negedge clk);
    clear_mon();
    acc_mode = 1'b0; signed_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (!(read && index == 2'd1 && j == 1) && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    total++;
    if (cnt >= 200) begin
      bad++; $display("FAIL midrun reach RDB(0,1) got=timeout exp=reached");
    end
    #1 reset = 1'b0;
    #1;
    total++;
    if ({busy, read, write, finish, error, index, i, j, write_data} !== '0) begin
      bad++; $display("FAIL midrun async reset got=%b/%b/%b/%0d exp=0", busy, read, write, write_data);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    total++;
    if (got_q.size() != 1 || busy !== 1'b0 || n_fin != 0) begin
      bad++; $display("FAIL midrun no resume got=writes%0d busy%b fin%0d exp=1/0/0",
                      got_q.size(), busy, n_fin);
    end
    fill_random(2, 2, 2);
    run_mm(1'b1, 1'b1, "after_reset");
  endtask

  task automatic test_ignored_starts();
    int cnt;
    bit got;
    fill_random(2, 1, 2);
    @(negedge clk);
    clear_mon();
    acc_mode = 1'b0; start = 1'b1;
    cnt = 0; got = 0;
    while (!got && cnt < 200) begin
      @(negedge clk);
      cnt++;
      start = (cnt == 3);
      if (finish) begin got = 1; start = 1'b1; end
    end
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    total++;
    if (!got || cnt != 5 + 4*3 || n_fin != 1 || busy !== 1'b0 || got_q.size() != 4) begin
      bad++; $display("FAIL ignored_starts got=lat%0d fin%0d busy%b wr%0d exp=17/1/0/4",
                      cnt, n_fin, busy, got_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_known_2x2();
    test_neg_one();
    test_acc();
    test_dim_errors();
    test_random();
    test_reset_midrun();
    test_ignored_starts();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
